// File: rtl/dct_da_sequencer.sv
// Sample collector and strobe sequencer for the bit-serial distributed-arithmetic DCT lanes.
// Double-buffers 8-sample blocks, runs SMP_W shift cycles per block, then offers a valid/ready token.
module dct_da_sequencer #(
  parameter int SMP_W = 8,
  parameter int BLK_N = 8,
  parameter int IDX_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     smp_valid,
  input  logic signed [SMP_W-1:0]  smp_data,
  output logic                     smp_ready,
  output logic [BLK_N*SMP_W-1:0]   blk_data,
  output logic                     lane_load,
  output logic                     lane_shift_en,
  output logic                     acc_clr,
  output logic                     msb_cycle,
  output logic                     coef_capture,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic [IDX_W-1:0]         blk_idx,
  output logic                     busy
);

  localparam int CNT_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;
  localparam int BIT_W = (SMP_W > 1) ? $clog2(SMP_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CAPT, S_OUT} state_t;

  // Handshakes: a sample moves when smp_valid & smp_ready at a rising edge;
  // a block token moves when coef_valid & coef_ready at a rising edge.

  state_t                   state, state_nx;
  logic [BIT_W-1:0]         bit_cnt;
  logic [SMP_W-1:0]         fill_buf [BLK_N];
  logic [CNT_W-1:0]         fill_cnt;
  logic                     fill_full;
  logic [BLK_N*SMP_W-1:0]   blk_reg;
  logic                     accept, handshake, xfer;

  assign smp_ready = !fill_full;
  assign accept    = smp_valid && !fill_full;
  assign handshake = (state == S_OUT) && coef_ready;
  // Fill buffer drains into the block register whenever the engine is free on this edge.
  assign xfer      = fill_full && ((state == S_IDLE) || handshake);
  assign blk_data  = blk_reg;

  always_ff @(posedge clk) begin
    if (accept) fill_buf[fill_cnt] <= smp_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt  <= '0;
      fill_full <= 1'b0;
    end else if (accept) begin
      if (fill_cnt == CNT_W'(BLK_N - 1)) begin
        fill_cnt  <= '0;
        fill_full <= 1'b1;
      end else begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
    end else if (xfer) begin
      fill_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_reg <= '0;
    end else if (xfer) begin
      for (int i = 0; i < BLK_N; i++) blk_reg[SMP_W*i +: SMP_W] <= fill_buf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      blk_idx <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= (state == S_SHIFT) ? bit_cnt + BIT_W'(1) : '0;
      if (handshake) blk_idx <= blk_idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_nx      = state;
    lane_load     = 1'b0;
    acc_clr       = 1'b0;
    lane_shift_en = 1'b0;
    msb_cycle     = 1'b0;
    coef_capture  = 1'b0;
    coef_valid    = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: if (fill_full) state_nx = S_LOAD;
      S_LOAD: begin
        lane_load = 1'b1;
        acc_clr   = 1'b1;
        state_nx  = S_SHIFT;
      end
      S_SHIFT: begin
        lane_shift_en = 1'b1;
        if (bit_cnt == BIT_W'(SMP_W - 1)) begin
          msb_cycle = 1'b1;
          state_nx  = S_CAPT;
        end
      end
      S_CAPT: begin
        coef_capture = 1'b1;
        state_nx     = S_OUT;
      end
      S_OUT: begin
        coef_valid = 1'b1;
        if (coef_ready) state_nx = fill_full ? S_LOAD : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dct_da_sequencer.sv
// Bench for dct_da_sequencer: directed and random streams against a block-level timing model.
// A second instance with a 2-bit block index shares all inputs to exercise index wrap.
module tb_dct_da_sequencer;

  logic        clk = 1'b0;
  logic        reset, smp_valid, coef_ready;
  logic [7:0]  smp_data;

  logic        smp_ready, lane_load, lane_shift_en, acc_clr, msb_cycle;
  logic        coef_capture, coef_valid, busy;
  logic [63:0] blk_data;
  logic [15:0] blk_idx;

  logic        smp_ready_2, lane_load_2, lane_shift_en_2, acc_clr_2, msb_cycle_2;
  logic        coef_capture_2, coef_valid_2, busy_2;
  logic [63:0] blk_data_2;
  logic [1:0]  blk_idx_2;

  dct_da_sequencer #(.SMP_W(8), .BLK_N(8), .IDX_W(16)) dut (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_ready(smp_ready), .blk_data(blk_data), .lane_load(lane_load),
    .lane_shift_en(lane_shift_en), .acc_clr(acc_clr), .msb_cycle(msb_cycle),
    .coef_capture(coef_capture), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .blk_idx(blk_idx), .busy(busy)
  );

  dct_da_sequencer #(.SMP_W(8), .BLK_N(8), .IDX_W(2)) dut2 (
    .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_ready(smp_ready_2), .blk_data(blk_data_2), .lane_load(lane_load_2),
    .lane_shift_en(lane_shift_en_2), .acc_clr(acc_clr_2), .msb_cycle(msb_cycle_2),
    .coef_capture(coef_capture_2), .coef_valid(coef_valid_2), .coef_ready(coef_ready),
    .blk_idx(blk_idx_2), .busy(busy_2)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / reference model
  logic [63:0] exp_q[$];
  logic [7:0]  part_q[$];
  logic [63:0] cur_blk;
  logic [63:0] blk_w;
  int          phase;
  int unsigned idx_exp;
  int          cyc, loads;
  int          load_cyc_q[$];
  int          idx2_q[$];
  logic        acc_m, hs_m;

  // phase: -1 idle, 0 load, 1..8 shift, 9 capture, >=10 offering token
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      part_q.delete();
      cur_blk = '0;
      phase   = -1;
      idx_exp = 0;
    end else begin
      chk("lane_load",     lane_load,     phase == 0);
      chk("acc_clr",       acc_clr,       phase == 0);
      chk("lane_shift_en", lane_shift_en, phase >= 1 && phase <= 8);
      chk("msb_cycle",     msb_cycle,     phase == 8);
      chk("coef_capture",  coef_capture,  phase == 9);
      chk("coef_valid",    coef_valid,    phase >= 10);
      chk("busy",          busy,          phase >= 0);
      chk("smp_ready",     smp_ready,     exp_q.size() == 0);
      chk("blk_data",      blk_data,      cur_blk);
      chk("blk_idx",       blk_idx,       64'(idx_exp % 65536));
      chk("blk_idx_w2",    blk_idx_2,     64'(idx_exp % 4));
      chk("coef_valid_w2", coef_valid_2,  phase >= 10);

      acc_m = smp_valid && (exp_q.size() == 0);
      hs_m  = (phase >= 10) && coef_ready;
      if (hs_m) idx2_q.push_back(int'(blk_idx_2));
      if ((phase == -1 || hs_m) && exp_q.size() != 0) begin
        cur_blk = exp_q.pop_front();
        phase   = 0;
        loads++;
        load_cyc_q.push_back(cyc + 1);
      end else if (hs_m) begin
        phase = -1;
      end else if (phase >= 0 && phase < 10) begin
        phase++;
      end
      if (hs_m) idx_exp++;
      if (acc_m) begin
        part_q.push_back(smp_data);
        if (part_q.size() == 8) begin
          for (int i = 0; i < 8; i++) blk_w[8*i +: 8] = part_q[i];
          exp_q.push_back(blk_w);
          part_q.delete();
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    logic acc;
    int   budget;
    acc       = 1'b0;
    budget    = 0;
    smp_valid = 1'b1;
    smp_data  = d;
    do begin
      @(negedge clk);
      acc = smp_ready;
      tick();
      budget++;
    end while (!acc && budget < 200);
    smp_valid = 1'b0;
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic wait_negedge_on_load(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lane_load && n < 40);
    chk("load_seen", lane_load, 1'b1);
  endtask

  task automatic wait_negedge_on_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!coef_valid && n < 40);
    chk("valid_seen", coef_valid, 1'b1);
  endtask

  int n_lat, ld0, lq0;
  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; smp_valid = 1'b0; smp_data = '0; coef_ready = 1'b1;
    phase = -1; idx_exp = 0; cyc = 0; loads = 0; cur_blk = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Step 1: samples 1..8 back to back, token taken immediately
    for (int i = 1; i <= 8; i++) send(8'(i));
    wait_negedge_on_load(n_lat);
    chk("t1_load_latency", 64'(n_lat), 64'd2);
    chk("t1_blk_data", blk_data, 64'h0807060504030201);
    wait_negedge_on_valid();
    chk("t1_blk_idx", blk_idx, 64'd0);
    tick();
    repeat (12) tick();

    // Step 2: sustained stream of four blocks, load spacing must settle at 11
    lq0 = load_cyc_q.size();
    send(8'h80); send(8'h7f); send(8'hff); send(8'h00);
    for (int i = 0; i < 28; i++) send(8'($urandom));
    repeat (25) tick();
    chk("t2_loads", 64'(load_cyc_q.size() - lq0), 64'd4);
    if (load_cyc_q.size() - lq0 == 4)
      for (int k = 1; k < 4; k++)
        chk("t2_spacing", 64'(load_cyc_q[lq0+k] - load_cyc_q[lq0+k-1]), 64'd11);
    chk("t2_blk_idx", blk_idx, 64'd5);

    // Step 3: back-pressure for 30 cycles while the stream keeps going
    coef_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'($urandom));
    smp_valid = 1'b1;
    smp_data  = 8'h5a;
    repeat (30) tick();
    chk("t3_ready_low", smp_ready, 1'b0);
    chk("t3_valid_held", coef_valid, 1'b1);
    coef_ready = 1'b1;
    send(8'h5a);
    for (int i = 0; i < 7; i++) send(8'($urandom));
    repeat (25) tick();

    // Step 4: eighth sample accepted on the handshake edge
    coef_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(8'($urandom));
    repeat (15) tick();
    ld0 = loads;
    smp_valid  = 1'b1;
    smp_data   = 8'hc3;
    coef_ready = 1'b1;
    tick();
    smp_valid = 1'b0;
    repeat (15) tick();
    chk("t4_one_load", 64'(loads - ld0), 64'd1);
    repeat (10) tick();

    // Step 5: reset in the middle of shifting with a partial fill pending
    for (int i = 0; i < 8; i++) send(8'($urandom));
    wait_negedge_on_load(n_lat);
    tick();
    for (int i = 0; i < 3; i++) send(8'($urandom));
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_shift_off", lane_shift_en, 1'b0);
    chk("t5_busy_off", busy, 1'b0);
    chk("t5_blk_data", blk_data, 64'd0);
    chk("t5_ready", smp_ready, 1'b1);
    chk("t5_idx", blk_idx, 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    wait_negedge_on_load(n_lat);
    chk("t5_first_block", blk_data, 64'h1716151413121110);
    wait_negedge_on_valid();
    chk("t5_blk_idx", blk_idx, 64'd0);
    tick();
    repeat (5) tick();

    // Step 6: random valid and ready
    for (int i = 0; i < 300; i++) begin
      smp_valid  = 1'($urandom_range(0, 1));
      smp_data   = 8'($urandom);
      coef_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    smp_valid  = 1'b0;
    coef_ready = 1'b1;
    repeat (40) tick();

    // 2-bit index instance: first five handed-off indices
    chk("w2_count", 64'(idx2_q.size() >= 5), 64'd1);
    if (idx2_q.size() >= 5)
      for (int k = 0; k < 5; k++) chk("w2_idx_seq", 64'(idx2_q[k]), 64'(exp_seq[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
